// File: rtl/deshifter.sv
// Serial-to-parallel receive stage behind the shifter; define DESHIFTER_PARITY_EN for a trailing even-parity bit.
// Latency: valid rises one cycle after the final frame bit; word held until ready, a full holder drops and flags overrun.
module deshifter #(
    parameter int WIDTH     = 7,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           din,
    input  logic           din_valid,
    output logic [WIDTH:0] data,
    output logic           valid,
    input  logic           ready,
    output logic           overrun,
    output logic           frame_err,
    output logic           parity_err
);
    localparam int            CW   = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic [WIDTH:0] sreg;

    logic [CW-1:0]  count_cur;
    logic [WIDTH:0] din_w;
    logic [WIDTH:0] base;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] word;
    logic           last_bit;
    logic           load;
    logic           abort;

    // A frame always starts from an empty register so stale bits never leak in.
    always_comb begin
        din_w     = '0;
        din_w[0]  = din;
        base      = (state == IDLE) ? '0 : sreg;
        count_cur = (state == IDLE) ? '0 : count;
        if (MSB_FIRST)
            shifted = (base << 1) | din_w;
        else
            shifted = (base >> 1) | (din_w << WIDTH);
        last_bit  = din_valid && (state != PARITY) && (count_cur == LAST);
        abort     = !din_valid && (state != IDLE);
`ifdef DESHIFTER_PARITY_EN
        load      = din_valid && (state == PARITY);
        word      = sreg;
`else
        load      = last_bit;
        word      = shifted;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            sreg       <= '0;
            data       <= '0;
            valid      <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            frame_err <= abort;
            if (abort) begin
                state <= IDLE;
                count <= '0;
            end else if (din_valid) begin
                if (state == PARITY) begin
                    state <= IDLE;
                    count <= '0;
`ifdef DESHIFTER_PARITY_EN
                    if (^{sreg, din})
                        parity_err <= 1'b1;
`endif
                end else if (last_bit) begin
`ifdef DESHIFTER_PARITY_EN
                    state <= PARITY;
`else
                    state <= IDLE;
`endif
                    sreg  <= shifted;
                    count <= '0;
                end else begin
                    state <= SHIFT;
                    sreg  <= shifted;
                    count <= count_cur + 1'b1;
                end
            end

            // A completing word wins over consumption; with ready it simply replaces the old one.
            if (load) begin
                if (!valid || ready) begin
                    data  <= word;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_deshifter.sv
// Directed bench for deshifter: MSB-first and LSB-first instances share one serial stream.
module tb_deshifter;
`ifdef DESHIFTER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       ready;
    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l;
    logic       ovr_m, ovr_l;
    logic       ferr_m, ferr_l;
    logic       perr_m, perr_l;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    deshifter #(.WIDTH(7), .MSB_FIRST(1'b1)) u_m (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .data(data_m), .valid(valid_m), .ready(ready),
        .overrun(ovr_m), .frame_err(ferr_m), .parity_err(perr_m)
    );

    deshifter #(.WIDTH(7), .MSB_FIRST(1'b0)) u_l (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .data(data_l), .valid(valid_l), .ready(ready),
        .overrun(ovr_l), .frame_err(ferr_l), .parity_err(perr_l)
    );

    // Reference model: collect a frame's bits in a queue, then place them by arithmetic.
    bit         q[$];
    logic [7:0] md_m, md_l;
    logic       mvalid, movr, mferr, mperr;
    logic [7:0] wm, wl;
    bit         done, px;

    always @(posedge clk) begin
        mferr = 1'b0;
        if (!reset) begin
            q.delete();
            md_m = 8'h00; md_l = 8'h00;
            mvalid = 1'b0; movr = 1'b0; mperr = 1'b0;
        end else begin
            done = 1'b0;
            if (din_valid) begin
                q.push_back(din);
                if (q.size() == NB) done = 1'b1;
            end else if (q.size() > 0) begin
                q.delete();
                mferr = 1'b1;
            end
            if (done) begin
                px = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    wm[7 - i] = q[i];
                    wl[i]     = q[i];
                end
                for (int i = 0; i < NB; i++) px = px ^ q[i];
                q.delete();
                if (NB == 9 && px) mperr = 1'b1;
                if (!mvalid || ready) begin
                    md_m = wm; md_l = wl; mvalid = 1'b1;
                end else begin
                    movr = 1'b1;
                end
            end else if (mvalid && ready) begin
                mvalid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_valid_m", {31'd0, valid_m}, {31'd0, mvalid});
            chk("cyc_valid_l", {31'd0, valid_l}, {31'd0, mvalid});
            chk("cyc_data_m", {24'd0, data_m}, {24'd0, md_m});
            chk("cyc_data_l", {24'd0, data_l}, {24'd0, md_l});
            chk("cyc_ovr", {30'd0, ovr_m, ovr_l}, {30'd0, movr, movr});
            chk("cyc_ferr", {30'd0, ferr_m, ferr_l}, {30'd0, mferr, mferr});
            chk("cyc_perr", {30'd0, perr_m, perr_l}, {30'd0, mperr, mperr});
        end
    end

    task automatic cyc(input logic v, input logic b);
        din_valid = v;
        din       = b;
        @(negedge clk);
    endtask

    // Bits go out b[7] first; good=0 sends the wrong parity bit; rl raises ready on the completing bit.
    task automatic send(input logic [7:0] b, input bit good, input bit rl);
        logic [8:0] bits;
        bits = {b, (^b) ^ !good};
        for (int i = 0; i < NB; i++) begin
            if (rl && i == NB - 1) ready = 1'b1;
            cyc(1'b1, bits[8 - i]);
        end
    endtask

    initial begin
        reset = 1'b0; din = 1'b0; din_valid = 1'b0; ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'd0, valid_m}, 32'd0);
        chk("rst_data", {24'd0, data_m}, 32'd0);
        chk("rst_flags", {29'd0, ovr_m, ferr_m, perr_m}, 32'd0);
        reset = 1'b1;

        send(8'hC1, 1'b1, 1'b0);
        chk("c1_valid", {31'd0, valid_m}, 32'd1);
        chk("c1_data_m", {24'd0, data_m}, 32'hC1);
        chk("c1_data_l", {24'd0, data_l}, 32'h83);
        chk("c1_model", {24'd0, md_m}, 32'hC1);
        chk("c1_ovr", {31'd0, ovr_m}, 32'd0);
        ready = 1'b1;
        cyc(1'b0, 1'b0);
        ready = 1'b0;
        chk("c1_consumed", {31'd0, valid_m}, 32'd0);
        chk("c1_held", {24'd0, data_m}, 32'hC1);

        ready = 1'b1;
        send(8'hA5, 1'b1, 1'b0);
        chk("b2b_a5", {23'd0, valid_m, data_m}, {23'd0, 1'b1, 8'hA5});
        send(8'h3C, 1'b1, 1'b0);
        chk("b2b_3c", {23'd0, valid_m, data_m}, {23'd0, 1'b1, 8'h3C});
        chk("b2b_flags", {30'd0, ovr_m, ferr_m}, 32'd0);
        cyc(1'b0, 1'b0);
        ready = 1'b0;

        send(8'h55, 1'b1, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        chk("ovr_data", {24'd0, data_m}, 32'h55);
        chk("ovr_flag", {30'd0, valid_m, ovr_m}, 32'd3);
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        chk("ovr_sticky", {31'd0, ovr_m}, 32'd1);
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        reset = 1'b1;
        chk("ovr_rst", {31'd0, ovr_m}, 32'd0);

        send(8'h55, 1'b1, 1'b0);
        send(8'hAA, 1'b1, 1'b1);
        ready = 1'b0;
        chk("swap_data", {24'd0, data_m}, 32'hAA);
        chk("swap_flags", {30'd0, valid_m, ovr_m}, 32'd2);

        cyc(1'b1, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("abort_ferr", {31'd0, ferr_m}, 32'd1);
        chk("abort_hold", {23'd0, valid_m, data_m}, {23'd0, 1'b1, 8'hAA});
        cyc(1'b0, 1'b0);
        chk("abort_pulse", {31'd0, ferr_m}, 32'd0);
        ready = 1'b1;
        cyc(1'b0, 1'b0);
        ready = 1'b0;
        send(8'h0F, 1'b1, 1'b0);
        chk("post_abort_m", {24'd0, data_m}, 32'h0F);
        chk("post_abort_l", {24'd0, data_l}, 32'hF0);

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
        reset = 1'b0;
        cyc(1'b1, 1'b1);
        chk("midrst_out", {20'd0, data_m, valid_m, ovr_m, ferr_m, perr_m}, 32'd0);
        reset = 1'b1;
        send(8'hF0, 1'b1, 1'b0);
        chk("post_rst_m", {24'd0, data_m}, 32'hF0);
        chk("post_rst_l", {24'd0, data_l}, 32'h0F);

`ifdef DESHIFTER_PARITY_EN
        ready = 1'b1;
        send(8'hC1, 1'b1, 1'b0);
        chk("par_good", {23'd0, perr_m, data_m}, {23'd0, 1'b0, 8'hC1});
        send(8'hC1, 1'b0, 1'b0);
        chk("par_bad", {23'd0, perr_m, data_m}, {23'd0, 1'b1, 8'hC1});
        ready = 1'b0;
        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        chk("par_sticky", {31'd0, perr_m}, 32'd1);
`else
        chk("par_off", {30'd0, perr_m, perr_l}, 32'd0);
`endif

        cyc(1'b0, 1'b0); cyc(1'b0, 1'b0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/deshifter.md
Name: deshifter

Overview:
- Serial-to-parallel receive stage that sits directly downstream of the shifter.
- Samples the shifter's serial `out` bit while the shifter reports non-empty, and assembles each WIDTH+1 bits into a parallel word.
- Presents each word on a valid/ready holding register to the next consumer.
- Flags overrun, aborted frames and, optionally, parity errors.

Parameters:
WIDTH, 7, MSB index of the data word; word is WIDTH+1 bits (matches the shifter's WIDTH).
MSB_FIRST, 1, 1 = first received bit lands in data[WIDTH]; 0 = first bit lands in data[0].

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block)
din  input  1  serial data bit (driven from shifter out)
din_valid  input  1  din carries a valid bit this cycle (driven from !empty of the shifter)
data  output  WIDTH+1  assembled word; held stable while valid=1
valid  output  1  data holds an unconsumed word
ready  input  1  consumer accepts data when valid&&ready at a rising edge
overrun  output  1  sticky: a completed word was dropped because the holding register was full
frame_err  output  1  one-cycle pulse: din_valid dropped mid-frame
parity_err  output  1  sticky parity failure (optional feature; otherwise constant 0)

Behaviour:
- Reset (reset==0 at edge): state=IDLE, bit counter=0, shift register=0, data=0, valid=0, overrun=0, frame_err=0, parity_err=0. Reset overrides every other event, including mid-frame.
- States:
  - IDLE: waiting for the first bit.
  - SHIFT: collecting data bits.
  - PARITY: exists only with the optional feature.
- IDLE: on din_valid=1, sample din as bit 0 of the frame, count=1, go to SHIFT. If WIDTH==0, the frame completes on that same edge.
- SHIFT: each edge with din_valid=1 samples din and increments count.
  - MSB_FIRST=1: shift left, inserting at LSB.
  - MSB_FIRST=0: shift right, inserting at MSB.
- Frame completes on the edge that samples bit WIDTH (count reaches WIDTH+1).
  - Without parity: the word moves to the holding register on that same edge, so valid rises one cycle after the last bit is presented.
  - Then go to IDLE. A back-to-back frame may start on the next edge; there are no dead cycles.
- Abort: din_valid=0 while in SHIFT/PARITY with count>0 discards the partial word, sets frame_err=1 for exactly one cycle, returns to IDLE and clears count. Holding register and valid are unaffected.
- Holding register:
  - valid&&ready at an edge clears valid, unless a new word completes on the same edge; in that case data takes the new word and valid stays 1 (no overrun).
  - Word completes while valid=1 and ready=0: new word dropped, data unchanged, overrun set and held until reset.
  - ready has no effect when valid=0.
- data changes only when a word is loaded; it is never cleared on consumption.
- No combinational paths from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: DESHIFTER_PARITY_EN.
- Defined:
  - Each frame carries one extra trailing even-parity bit after the WIDTH+1 data bits.
  - After bit WIDTH the FSM enters PARITY. The next din_valid=1 edge samples the parity bit and loads the word into the holding register (same overrun/ready rules as above).
  - If XOR(data bits, parity bit)!=0, parity_err is set sticky; the word is still delivered.
  - din_valid=0 in PARITY is an abort, as in SHIFT.
- Undefined: no PARITY state, frame is exactly WIDTH+1 bits, parity_err tied to 0.

Test Plan:
- Reset then frame: reset=0 for 2 edges, then reset=1. Drive 8 consecutive valid bits 1,1,0,0,0,0,0,1 with MSB_FIRST=1 and ready=0 -> after the 8th edge data=8'hC1, valid=1, overrun=0; with ready=1 on the next edge -> valid=0, data stays 8'hC1.
- LSB-first: MSB_FIRST=0, same bit sequence -> data=8'h83.
- Back-to-back with ready held 1: frames 8'hA5 then 8'h3C with no gap -> two valid cycles carrying A5 then 3C; overrun=0, frame_err=0.
- Overrun: ready=0; send 8'h55 then 8'hAA -> data stays 8'h55, valid=1, overrun=1 until reset. Repeat with ready=1 exactly on AA's completion edge -> data=8'hAA, valid=1, overrun=0.
- Abort and reset: drop din_valid after 3 bits -> frame_err high one cycle, valid unchanged; next full frame 8'h0F decodes correctly. Assert reset=0 after 5 bits -> all outputs 0; the following frame 8'hF0 decodes as F0.
- DESHIFTER_PARITY_EN defined: send 8'hC1 + parity 1 -> data=C1, parity_err=0. Send 8'hC1 + parity 0 -> data=C1, parity_err=1 (sticky).
